// File: rtl/freq_gate_counter_pkg.sv
// Shared types and constants for the gated frequency counter.
// Build option: FREQ_GATE_COUNTER_OVF_SAT_EN selects saturating event count with overflow flag.
package freq_gate_counter_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/freq_gate_counter_sync_edge.sv
// Brings the asynchronous signal under test into the CLK domain and emits a
// registered one-cycle pulse for every rising edge.
module freq_gate_counter_sync_edge
  import freq_gate_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sig_async,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The pulse is registered so it appears three CLK edges after the input rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_async};
      prev_q     <= sync_q[SYNC_STAGES-1];
      edge_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts SIG_IN rising edges over GATE_CYCLES CLK cycles
// and hands the result over with a VALID/READY handshake. Option: FREQ_GATE_COUNTER_OVF_SAT_EN.
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int GATE_CYCLES = 10000000,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SIG_IN,
  input  logic             START,
  input  logic             CONT,
  output logic             BUSY,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  input  logic             READY,
  output logic             OVF
);

  localparam int                GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t             state, state_next;
  logic               edge_pulse;
  logic               gate_start;
  logic               gate_last;
  logic               evt_inc;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   evt_cnt;
  logic [CNT_W-1:0]   evt_final;

  freq_gate_counter_sync_edge u_sync_edge (
    .clk        (CLK),
    .rst_n      (RESETN),
    .sig_async  (SIG_IN),
    .edge_pulse (edge_pulse)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (START || CONT)        state_next = ST_GATE;
      ST_GATE: if (gate_cnt == GATE_LAST) state_next = ST_HOLD;
      ST_HOLD: if (READY)                state_next = CONT ? ST_GATE : ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state == ST_GATE);
    VALID      = (state == ST_HOLD);
    gate_start = (state != ST_GATE) && (state_next == ST_GATE);
    gate_last  = (state == ST_GATE) && (gate_cnt == GATE_LAST);
    evt_inc    = (state == ST_GATE) && edge_pulse;
  end

`ifdef FREQ_GATE_COUNTER_OVF_SAT_EN
  logic ovf_flag;
  logic ovf_final;
  logic ovf_q;

  // Count sticks at all-ones; any further edge marks the gate as overflowed.
  always_comb begin
    evt_final = evt_cnt;
    ovf_final = ovf_flag;
    if (evt_inc) begin
      if (&evt_cnt) ovf_final = 1'b1;
      else          evt_final = evt_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ovf_flag <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (gate_start)             ovf_flag <= 1'b0;
      else if (state == ST_GATE)  ovf_flag <= ovf_final;
      if (gate_last)              ovf_q    <= ovf_final;
    end
  end

  assign OVF = ovf_q;
`else
  always_comb begin
    evt_final = evt_cnt + CNT_W'(evt_inc);
  end

  assign OVF = 1'b0;
`endif

  // The final gate cycle's edge is folded in through evt_final when COUNT latches.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      gate_cnt <= '0;
      evt_cnt  <= '0;
      COUNT    <= '0;
    end else begin
      if (gate_start) begin
        gate_cnt <= '0;
        evt_cnt  <= '0;
      end else if (state == ST_GATE) begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        evt_cnt  <= evt_final;
      end
      if (gate_last) COUNT <= evt_final;
    end
  end

endmodule

// File: doc/freq_gate_counter.md
FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 10000000, gate length in CLK cycles (minimum 2).
REQ-002 Parameter CNT_W, default 32, width of the event counter and result.
REQ-003 Port CLK  in  1  reference clock (crystal oscillator fabric output); all logic SHALL be in this single domain.
REQ-004 Port RESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 Port SIG_IN  in  1  signal under test, asynchronous to CLK.
REQ-006 Port START  in  1  single-cycle request to begin one measurement.
REQ-007 Port CONT  in  1  continuous mode; re-arm automatically after each handshake.
REQ-008 Port BUSY  out  1  high in GATE state.
REQ-009 Port COUNT  out  CNT_W  latched rising-edge count of the last completed gate.
REQ-010 Port VALID  out  1  result available; held until accepted.
REQ-011 Port READY  in  1  consumer accepts the result when VALID and READY are both high on a CLK edge.
REQ-012 Port OVF  out  1  event counter overflowed during the reported gate (see Configuration).

Function
REQ-013 SIG_IN SHALL pass a 2-stage synchronizer, then a rising-edge detector, giving a 1-cycle edge pulse 3 CLK cycles after the SIG_IN rise; the detector SHALL run in all states.
REQ-014 FSM states: IDLE, GATE, HOLD.
REQ-015 IDLE -> GATE when START=1 or CONT=1; gate and event counters SHALL clear on entry.
REQ-016 GATE: gate counter increments every cycle; event counter increments on each edge pulse present in a GATE cycle, including the final one.
REQ-017 GATE SHALL last exactly GATE_CYCLES cycles, then -> HOLD; COUNT/OVF latch the final count on that transition and VALID rises the same edge.
REQ-018 HOLD: VALID, COUNT, OVF SHALL remain stable until a cycle with READY=1; on that edge VALID falls, and next state is GATE if CONT=1, else IDLE.
REQ-019 START during GATE or HOLD SHALL be ignored (not queued).
REQ-020 Edges arriving while in IDLE or HOLD SHALL NOT be counted; maximum measurable SIG_IN frequency is CLK/2.
REQ-021 Deasserting CONT during GATE SHALL complete the current gate normally and return to IDLE after the handshake.

Reset
REQ-022 RESETN low SHALL immediately force state IDLE, BUSY=0, VALID=0, COUNT=0, OVF=0, all counters and synchronizer flops 0.
REQ-023 Reset mid-gate SHALL discard the partial measurement; no VALID SHALL follow release without a new START/CONT.

Configuration
REQ-024 Macro FREQ_GATE_COUNTER_OVF_SAT_EN defined: event counter saturates at all-ones and sets an overflow flag latched into OVF at gate end.
REQ-025 Macro undefined: event counter wraps modulo 2^CNT_W and OVF SHALL be tied 0.

Structure
REQ-026 Package freq_gate_counter_pkg SHALL hold the FSM state enum and the SYNC_STAGES=2 constant.
REQ-027 Sub-module freq_gate_counter_sync_edge SHALL contain the synchronizer and rising-edge detector; counters and FSM stay in the top.

Verification
REQ-028 GATE_CYCLES=100, SIG_IN period 4 CLK, START pulse -> after 100 BUSY cycles VALID=1, COUNT=25, OVF=0.
REQ-029 SIG_IN held 0 (and separately held 1), START -> COUNT=0, VALID=1.
REQ-030 READY held 0 for 50 cycles after VALID, START pulsed in HOLD -> VALID and COUNT stable, no new gate; READY=1 -> IDLE next cycle.
REQ-031 CONT=1, READY=1 -> BUSY re-asserts the cycle after each handshake; three consecutive results each 25.
REQ-032 RESETN low at gate cycle 40 -> BUSY=0, VALID=0 immediately; after release no VALID for 200 cycles without START.
REQ-033 CNT_W=4, GATE_CYCLES=100, period 4: with macro COUNT=15, OVF=1; without macro COUNT=9, OVF=0.
